// File: rtl/led_mode_ctrl.sv
// LED sequencer: synchronises and debounces four active-low keys, latches a pattern
// mode from each debounced press, and generates the step tick / phase for the decoder.
module led_mode_ctrl #(
  parameter int DEB_CYC  = 1_000_000,
  parameter int STEP_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [3:0] key_press,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       step,
  output logic [1:0] phase
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(STEP_CYC);

  typedef enum logic [2:0] {IDLE = 3'd0, FWD = 3'd1, REV = 3'd2, BLINK = 3'd3, ON = 3'd4} mode_e;

  logic [3:0]         sync1_q, sync2_q, stable_q, stable_d, press_q, press_d;
  logic [3:0][DW-1:0] dcnt_q, dcnt_d;
  mode_e              mode_q, mode_d, tgt;
  logic               chg_q, chg_d, step_q, step_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic [1:0]         phase_q, phase_d;

  // Per-key debounce: a change is accepted only after DEB_CYC stable cycles
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    dcnt_d   = dcnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DW'(DEB_CYC - 1)) begin
        stable_d[i] = sync2_q[i];
        dcnt_d[i]   = '0;
        press_d[i]  = ~sync2_q[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  always_comb begin
    tgt = IDLE;
    if      (press_q[0]) tgt = FWD;
    else if (press_q[1]) tgt = REV;
    else if (press_q[2]) tgt = BLINK;
    else if (press_q[3]) tgt = ON;
  end

  always_comb begin
    mode_d  = mode_q;
    chg_d   = 1'b0;
    scnt_d  = '0;
    step_d  = 1'b0;
    phase_d = '0;
    if (|press_q) begin
      chg_d  = 1'b1;
      mode_d = (tgt == mode_q) ? IDLE : tgt;
    end else if (mode_q == FWD || mode_q == REV || mode_q == BLINK) begin
      phase_d = phase_q;
      if (scnt_q == SW'(STEP_CYC - 1)) begin
        step_d  = 1'b1;
        phase_d = phase_q + 2'd1;
      end else begin
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 4'b1111;
      sync2_q  <= 4'b1111;
      stable_q <= 4'b1111;
      dcnt_q   <= '0;
      press_q  <= '0;
      mode_q   <= IDLE;
      chg_q    <= 1'b0;
      scnt_q   <= '0;
      step_q   <= 1'b0;
      phase_q  <= '0;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      press_q  <= press_d;
      mode_q   <= mode_d;
      chg_q    <= chg_d;
      scnt_q   <= scnt_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
    end
  end

  assign key_press = press_q;
  assign mode      = mode_q;
  assign mode_chg  = chg_q;
  assign step      = step_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with DEB_CYC=4, STEP_CYC=8: vector table plus
// hand-written reset sequence.
module tb_led_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key = 4'b1111;
  logic [3:0] key_press;
  logic [2:0] mode;
  logic       mode_chg, step;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  led_mode_ctrl #(.DEB_CYC(4), .STEP_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_press(key_press),
    .mode(mode), .mode_chg(mode_chg), .step(step), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         n;
    logic [3:0] kp;
    logic [2:0] md;
    logic       chg;
    logic       stp;
    logic [1:0] ph;
  } vec_t;

  vec_t vq[$];

  function automatic logic [10:0] pack(logic [3:0] kp, logic [2:0] md, logic chg, logic stp, logic [1:0] ph);
    return {kp, md, chg, stp, ph};
  endfunction

  task automatic add(logic [3:0] k, int n, logic [3:0] kp, logic [2:0] md, logic chg, logic stp, logic [1:0] ph);
    vec_t v;
    v.key = k; v.n = n; v.kp = kp; v.md = md; v.chg = chg; v.stp = stp; v.ph = ph;
    vq.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [10:0] exp);
    logic [10:0] act;
    act = {key_press, mode, mode_chg, step, phase};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got kp=%b mode=%0d chg=%b step=%b ph=%0d want kp=%b mode=%0d chg=%b step=%b ph=%0d",
               nm, act[10:7], act[6:4], act[3], act[2], act[1:0],
               exp[10:7], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    // bounce on key0: rejected
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 0, 2'd0);
    for (int b = 0; b < 5; b++) begin
      add(4'b1110, 3, 4'b0000, 3'd0, 0, 0, 2'd0);
      add(4'b1111, 1, 4'b0000, 3'd0, 0, 0, 2'd0);
    end
    // held low: press on 6th cycle, FWD next
    add(4'b1110, 5, 4'b0000, 3'd0, 0, 0, 2'd0);
    add(4'b1110, 1, 4'b0001, 3'd0, 0, 0, 2'd0);
    add(4'b1110, 1, 4'b0000, 3'd1, 1, 0, 2'd0);
    // FWD stepping: phase 1,2,3,0
    add(4'b1110, 7, 4'b0000, 3'd1, 0, 0, 2'd0);
    add(4'b1110, 1, 4'b0000, 3'd1, 0, 1, 2'd1);
    add(4'b1110, 7, 4'b0000, 3'd1, 0, 0, 2'd1);
    add(4'b1110, 1, 4'b0000, 3'd1, 0, 1, 2'd2);
    add(4'b1110, 7, 4'b0000, 3'd1, 0, 0, 2'd2);
    add(4'b1110, 1, 4'b0000, 3'd1, 0, 1, 2'd3);
    add(4'b1110, 7, 4'b0000, 3'd1, 0, 0, 2'd3);
    add(4'b1110, 1, 4'b0000, 3'd1, 0, 1, 2'd0);
    // key1+key2 together: REV wins, key2 dropped
    add(4'b1000, 5, 4'b0000, 3'd1, 0, 0, 2'd0);
    add(4'b1000, 1, 4'b0110, 3'd1, 0, 0, 2'd0);
    add(4'b1000, 1, 4'b0000, 3'd2, 1, 0, 2'd0);
    // release key1 (no pulse) while REV steps to phase 2
    add(4'b1010, 7, 4'b0000, 3'd2, 0, 0, 2'd0);
    add(4'b1010, 1, 4'b0000, 3'd2, 0, 1, 2'd1);
    add(4'b1010, 7, 4'b0000, 3'd2, 0, 0, 2'd1);
    add(4'b1010, 1, 4'b0000, 3'd2, 0, 1, 2'd2);
    // key1 again: toggle off to IDLE, phase cleared, quiet for 100 cycles
    add(4'b1000, 5, 4'b0000, 3'd2, 0, 0, 2'd2);
    add(4'b1000, 1, 4'b0010, 3'd2, 0, 0, 2'd2);
    add(4'b1000, 1, 4'b0000, 3'd0, 1, 0, 2'd0);
    add(4'b1000, 100, 4'b0000, 3'd0, 0, 0, 2'd0);

    #2 rst_n = 1'b0;
    #1 chk("reset_async", 11'd0);
    repeat (3) tick();
    chk("reset_hold", 11'd0);
    rst_n = 1'b1;

    for (int v = 0; v < vq.size(); v++) begin
      key = vq[v].key;
      for (int t = 0; t < vq[v].n; t++) begin
        tick();
        if (t == vq[v].n - 1)
          chk($sformatf("vec%0d", v), pack(vq[v].kp, vq[v].md, vq[v].chg, vq[v].stp, vq[v].ph));
        else
          chk($sformatf("vec%0d_mid%0d", v, t), pack(4'b0000, vq[v].md, 1'b0, 1'b0, vq[v].ph));
      end
    end

    // into BLINK, run to phase 2 mid-count, then async reset with key3 held
    key = 4'b1100;
    repeat (8) tick();
    chk("key2_release_quiet", pack(4'b0000, 3'd0, 0, 0, 2'd0));
    key = 4'b1000;
    repeat (5) tick();
    chk("key2_pre_press", pack(4'b0000, 3'd0, 0, 0, 2'd0));
    tick();
    chk("key2_press", pack(4'b0100, 3'd0, 0, 0, 2'd0));
    tick();
    chk("blink_enter", pack(4'b0000, 3'd3, 1, 0, 2'd0));
    repeat (16) tick();
    chk("blink_phase2", pack(4'b0000, 3'd3, 0, 1, 2'd2));
    repeat (3) tick();
    chk("blink_midcount", pack(4'b0000, 3'd3, 0, 0, 2'd2));
    key = 4'b0111;
    rst_n = 1'b0;
    #1 chk("midrun_reset_async", 11'd0);
    repeat (3) tick();
    chk("midrun_reset_hold", 11'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("key3_redeb%0d", e), 11'd0);
    end
    tick();
    chk("key3_press", pack(4'b1000, 3'd0, 0, 0, 2'd0));
    tick();
    chk("on_enter", pack(4'b0000, 3'd4, 1, 0, 2'd0));
    for (int t = 0; t < 20; t++) begin
      tick();
      chk($sformatf("on_hold%0d", t), pack(4'b0000, 3'd4, 0, 0, 2'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
